// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the white-balance control path.
// Mode/select codes, cfg address map, FSM state enums, init gain helpers.
// No logic; imported by the sequencer, its calibration timer and the bench.
package wb_ctrl_pkg;

  localparam logic [1:0] MODE_AUTO_GW     = 2'd0;
  localparam logic [1:0] MODE_AUTO_R      = 2'd1;
  localparam logic [1:0] MODE_MANUAL      = 2'd2;
  localparam logic [1:0] MODE_CALIBRATION = 2'd3;

  localparam logic [1:0] SEL_RED   = 2'd0;
  localparam logic [1:0] SEL_GREEN = 2'd1;
  localparam logic [1:0] SEL_BLUE  = 2'd2;

  typedef enum logic [2:0] {
    ADDR_MODE    = 3'd0,
    ADDR_R_COEF  = 3'd1,
    ADDR_G_COEF  = 3'd2,
    ADDR_B_COEF  = 3'd3,
    ADDR_CAL_CMD = 3'd4,
    ADDR_APPLY   = 3'd5,
    ADDR_RSVD6   = 3'd6,
    ADDR_RSVD7   = 3'd7
  } cfg_addr_e;

  typedef enum logic [2:0] {
    AP_IDLE     = 3'd0,
    AP_WAIT_SOF = 3'd1,
    AP_LOCK_R   = 3'd2,
    AP_LOCK_G   = 3'd3,
    AP_LOCK_B   = 3'd4
  } apply_state_e;

  typedef enum logic [1:0] {
    CAL_IDLE = 2'd0,
    CAL_WAIT = 2'd1,
    CAL_STB  = 2'd2
  } cal_state_e;

  // Gain "whole + num_1024/1024" in px_width.fract_width fixed point.
  function automatic logic [31:0] gain_fixed(input int px_width, input int fract_width,
                                             input int whole, input int num_1024);
    logic [63:0] v;
    v = 64'(whole) << fract_width;
    if (fract_width >= 10) v = v + (64'(num_1024) << (fract_width - 10));
    else                   v = v + (64'(num_1024) >> (10 - fract_width));
    v = v & ((64'd1 << (px_width + fract_width)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] init_coef_r(input int px_width, input int fract_width);
    return gain_fixed(px_width, fract_width, 1, 119);
  endfunction

  function automatic logic [31:0] init_coef_g(input int px_width, input int fract_width);
    return gain_fixed(px_width, fract_width, 1, 0);
  endfunction

  function automatic logic [31:0] init_coef_b(input int px_width, input int fract_width);
    return gain_fixed(px_width, fract_width, 2, 39);
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Control bundle from the sequencer into the white-balance corrector.
// All fields are registered by the master; no handshake on this bundle.
// Corrector must sample man_* whenever man_lock is high; no backpressure.
interface wb_ctrl_if;
  logic [1:0]  mode;
  logic [1:0]  man_sel;
  logic [31:0] man_coef;
  logic        man_lock;
  logic        cal_stb;

  modport master (output mode, man_sel, man_coef, man_lock, cal_stb);
  modport slave  (input  mode, man_sel, man_coef, man_lock, cal_stb);
endinterface

// File: rtl/wb_cal_timer.sv
// Calibration timer: counts SOFs after a command and fires one strobe.
// Strobe appears the cycle after the CAL_FRAMES-th counted SOF.
// No backpressure; command restarts, abort cancels without a strobe.
module wb_cal_timer
  import wb_ctrl_pkg::*;
#(
  parameter int CAL_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd,
  input  logic abort,
  input  logic sof,
  output logic stb,
  output logic busy,
  output logic done
);

  localparam int FRAMES = (CAL_FRAMES < 1) ? 1 : CAL_FRAMES;
  localparam int CW     = $clog2(FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMES);

  cal_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          stb_d, busy_d, done_d;

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAL_IDLE;
      cnt   <= '0;
      stb   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      stb   <= stb_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // next state: command wins (a coincident SOF is not counted), then abort
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (cmd) begin
      state_nxt = CAL_WAIT;
      cnt_nxt   = '0;
    end else if (abort) begin
      state_nxt = CAL_IDLE;
    end else begin
      case (state)
        CAL_WAIT: begin
          if (sof) begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
            if (cnt_nxt == CNT_MAX) state_nxt = CAL_STB;
          end
        end
        CAL_STB: state_nxt = CAL_IDLE;
        default: state_nxt = CAL_IDLE;
      endcase
    end
  end

  // output decode from the next state so outputs line up with the state register
  always_comb begin
    stb_d  = (state_nxt == CAL_STB);
    busy_d = (state_nxt != CAL_IDLE);
    done_d = done;
    if (cmd) done_d = 1'b0;
    else if (state == CAL_STB && state_nxt == CAL_IDLE && !abort) done_d = 1'b1;
  end

endmodule

// File: rtl/wb_ctrl_sequencer.sv
// Shadows WB gains/mode from a cfg port and pushes them as a R/G/B lock burst.
// Burst starts 1 cycle after APPLY (or after next SOF), 3 lock cycles, ready at +4.
// cfg_ready_o low for the whole burst; every write stalls, keeping shadows coherent.
module wb_ctrl_sequencer
  import wb_ctrl_pkg::*;
#(
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int CAL_FRAMES  = 4,
  parameter int SYNC_APPLY  = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_wr_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic        cfg_ready_o,
  input  logic        sof_i,
  wb_ctrl_if.master   wb_ctrl_o,
  output logic        cal_busy_o,
  output logic        cal_done_o
);

  localparam int COEF_WIDTH = PX_WIDTH + FRACT_WIDTH;
  localparam logic [COEF_WIDTH-1:0] INIT_R = COEF_WIDTH'(init_coef_r(PX_WIDTH, FRACT_WIDTH));
  localparam logic [COEF_WIDTH-1:0] INIT_G = COEF_WIDTH'(init_coef_g(PX_WIDTH, FRACT_WIDTH));
  localparam logic [COEF_WIDTH-1:0] INIT_B = COEF_WIDTH'(init_coef_b(PX_WIDTH, FRACT_WIDTH));

  logic                  wr_acc;
  logic                  wr_apply, wr_cal, wr_mode;
  logic [1:0]            mode_q;
  logic [COEF_WIDTH-1:0] shadow_r, shadow_g, shadow_b;

  apply_state_e          ap_state, ap_state_nxt;
  logic                  lock_d;
  logic [1:0]            sel_d;
  logic [COEF_WIDTH-1:0] coef_d;
  logic                  man_lock_q;
  logic [1:0]            man_sel_q;
  logic [31:0]           man_coef_q;
  logic                  cal_stb_q;

  // only the low COEF_WIDTH bits (or two for MODE) carry meaning
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata_i;

  assign cfg_ready_o = (ap_state == AP_IDLE);
  assign wr_acc      = cfg_wr_i && cfg_ready_o;
  assign wr_apply    = wr_acc && (cfg_addr_i == ADDR_APPLY);
  assign wr_mode     = wr_acc && (cfg_addr_i == ADDR_MODE);
  assign wr_cal      = wr_acc && (cfg_addr_i == ADDR_CAL_CMD) && (mode_q == MODE_CALIBRATION);

  // mode and shadow coefficient registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q   <= MODE_AUTO_GW;
      shadow_r <= INIT_R;
      shadow_g <= INIT_G;
      shadow_b <= INIT_B;
    end else if (wr_acc) begin
      case (cfg_addr_i)
        ADDR_MODE:   mode_q   <= cfg_wdata_i[1:0];
        ADDR_R_COEF: shadow_r <= cfg_wdata_i[COEF_WIDTH-1:0];
        ADDR_G_COEF: shadow_g <= cfg_wdata_i[COEF_WIDTH-1:0];
        ADDR_B_COEF: shadow_b <= cfg_wdata_i[COEF_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // apply FSM state and registered burst outputs; sel/coef hold between bursts
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ap_state   <= AP_IDLE;
      man_lock_q <= 1'b0;
      man_sel_q  <= SEL_RED;
      man_coef_q <= '0;
    end else begin
      ap_state   <= ap_state_nxt;
      man_lock_q <= lock_d;
      if (lock_d) begin
        man_sel_q  <= sel_d;
        man_coef_q <= 32'(coef_d);
      end
    end
  end

  // apply FSM next state; an SOF in the APPLY cycle is seen while still idle
  always_comb begin
    ap_state_nxt = ap_state;
    case (ap_state)
      AP_IDLE:     if (wr_apply) ap_state_nxt = (SYNC_APPLY != 0) ? AP_WAIT_SOF : AP_LOCK_R;
      AP_WAIT_SOF: if (sof_i) ap_state_nxt = AP_LOCK_R;
      AP_LOCK_R:   ap_state_nxt = AP_LOCK_G;
      AP_LOCK_G:   ap_state_nxt = AP_LOCK_B;
      AP_LOCK_B:   ap_state_nxt = AP_IDLE;
      default:     ap_state_nxt = AP_IDLE;
    endcase
  end

  // burst output decode from the next state, registered above
  always_comb begin
    lock_d = 1'b0;
    sel_d  = SEL_RED;
    coef_d = shadow_r;
    case (ap_state_nxt)
      AP_LOCK_R: begin lock_d = 1'b1; sel_d = SEL_RED;   coef_d = shadow_r; end
      AP_LOCK_G: begin lock_d = 1'b1; sel_d = SEL_GREEN; coef_d = shadow_g; end
      AP_LOCK_B: begin lock_d = 1'b1; sel_d = SEL_BLUE;  coef_d = shadow_b; end
      default: ;
    endcase
  end

  wb_cal_timer #(.CAL_FRAMES(CAL_FRAMES)) u_cal_timer (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .cmd   (wr_cal),
    .abort (wr_mode && (cfg_wdata_i[1:0] != MODE_CALIBRATION)),
    .sof   (sof_i),
    .stb   (cal_stb_q),
    .busy  (cal_busy_o),
    .done  (cal_done_o)
  );

  assign wb_ctrl_o.mode     = mode_q;
  assign wb_ctrl_o.man_lock = man_lock_q;
  assign wb_ctrl_o.man_sel  = man_sel_q;
  assign wb_ctrl_o.man_coef = man_coef_q;
  assign wb_ctrl_o.cal_stb  = cal_stb_q;

endmodule
